// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

    localparam int unsigned DEFAULT_REG_AW = 5;
    localparam int unsigned LU_CNT_W       = 2;
    localparam int unsigned MDU_CNT_W      = 4;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_HOLD  = 2'd1,
        MEM_WAIT = 2'd2
    } hazardState_t;

endpackage

// File: rtl/hazard_down_counter.sv
// Loadable down-counter with zero flag; load wins over decrement.
module hazard_down_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (dec) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard/stall controller for the 5-stage MIPS pipeline with branches resolved in ID.
// Handles load-use, branch-operand and HI/LO hazards, memory-wait freeze and taken-branch flush.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = DEFAULT_REG_AW,
    parameter int unsigned LU_BUBBLES = 1,
    parameter int unsigned MDU_LAT    = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_branch,
    input  logic              id_taken,
    input  logic              id_mdu,
    input  logic              id_hilo_rd,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mdu_start,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_mem_read,
    input  logic              mem_access,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              pipe_freeze,
    output logic [CNT_W-1:0]  stall_count
);

    hazardState_t state, stateNext, effState;

    logic exMatch, memMatch, freeze, luDetect, branchHaz, mduBusy;
    logic luLoad, luDec, luZero, mduZero;
    logic [LU_CNT_W-1:0]  luCnt;
    logic [MDU_CNT_W-1:0] mduCnt;

    // Register 0 is hardwired, so it never creates a dependency.
    assign exMatch  = (ex_rd != '0) &&
                      ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
    assign memMatch = (mem_rd != '0) &&
                      ((id_use_rs && (id_rs == mem_rd)) || (id_use_rt && (id_rt == mem_rd)));

    assign freeze    = mem_access && !mem_ready;
    assign luDetect  = ex_mem_read && exMatch;
    assign branchHaz = id_branch && ((ex_reg_write && exMatch) || (mem_mem_read && memMatch));
    assign mduBusy   = (id_mdu || id_hilo_rd) && (mduCnt != '0);

    hazard_down_counter #(.W(LU_CNT_W)) luCounter (
        .clk     (clk),
        .rst     (rst),
        .load    (luLoad),
        .loadVal (LU_CNT_W'(LU_BUBBLES - 1)),
        .dec     (luDec),
        .count   (luCnt),
        .zero    (luZero)
    );

    hazard_down_counter #(.W(MDU_CNT_W)) mduCounter (
        .clk     (clk),
        .rst     (rst),
        .load    (ex_mdu_start),
        .loadVal (MDU_CNT_W'(MDU_LAT - 1)),
        .dec     (!freeze && !mduZero),
        .count   (mduCnt),
        .zero    (mduZero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    // The cycle a freeze ends behaves as the state it interrupted, so no bubble is lost.
    always_comb begin
        case (state)
            LU_HOLD:  effState = LU_HOLD;
            MEM_WAIT: effState = luZero ? RUN : LU_HOLD;
            default:  effState = RUN;
        endcase
    end

    always_comb begin
        stateNext    = effState;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        luLoad       = 1'b0;
        luDec        = 1'b0;
        if (rst) begin
            stateNext = RUN;
        end else if (freeze) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            stateNext   = MEM_WAIT;
        end else if (effState == LU_HOLD) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            luDec        = 1'b1;
            stateNext    = (luCnt == LU_CNT_W'(1)) ? RUN : LU_HOLD;
        end else if (luDetect) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            luLoad       = 1'b1;
            stateNext    = (LU_BUBBLES > 1) ? LU_HOLD : RUN;
        end else if (branchHaz || mduBusy) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (id_branch && id_taken) begin
            if_id_flush = 1'b1;
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (!pc_write && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scenario bench for hazard_control_unit: expectations queued as stimulus is driven,
// popped and compared once the combinational outputs settle.
module tb_hazard_control_unit;

    localparam logic [4:0] E_RUN   = 5'b11000;
    localparam logic [4:0] E_STALL = 5'b00010;
    localparam logic [4:0] E_FLUSH = 5'b11100;
    localparam logic [4:0] E_FRZ   = 5'b00001;

    logic        clk, rst;
    logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
    logic        id_use_rs, id_use_rt, id_branch, id_taken, id_mdu, id_hilo_rd;
    logic        ex_reg_write, ex_mem_read, ex_mdu_start;
    logic        mem_mem_read, mem_access, mem_ready;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze;
    logic [31:0] stall_count;
    logic        satPc, satIfId, satFlush, satBubble, satFreeze;
    logic [2:0]  satCount;

    typedef struct {
        string       tag;
        logic [4:0]  outs;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sbQ[$];
    int          nTests = 0;
    int          nFail  = 0;
    logic [31:0] expStall = '0;

    hazard_control_unit #(.REG_AW(5), .LU_BUBBLES(2), .MDU_LAT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_branch(id_branch), .id_taken(id_taken), .id_mdu(id_mdu), .id_hilo_rd(id_hilo_rd),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mdu_start(ex_mdu_start), .mem_rd(mem_rd), .mem_mem_read(mem_mem_read),
        .mem_access(mem_access), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze), .stall_count(stall_count)
    );

    // Narrow counter instance to reach saturation quickly.
    hazard_control_unit #(.REG_AW(5), .LU_BUBBLES(2), .MDU_LAT(4), .CNT_W(3)) dutSat (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_branch(id_branch), .id_taken(id_taken), .id_mdu(id_mdu), .id_hilo_rd(id_hilo_rd),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mdu_start(ex_mdu_start), .mem_rd(mem_rd), .mem_mem_read(mem_mem_read),
        .mem_access(mem_access), .mem_ready(mem_ready),
        .pc_write(satPc), .if_id_write(satIfId), .if_id_flush(satFlush),
        .id_ex_bubble(satBubble), .pipe_freeze(satFreeze), .stall_count(satCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_branch = 1'b0; id_taken = 1'b0; id_mdu = 1'b0; id_hilo_rd = 1'b0;
        ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mdu_start = 1'b0;
        mem_rd = '0; mem_mem_read = 1'b0; mem_access = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic pushExp(input string tag, input logic [4:0] e);
        exp_t x;
        x.tag  = tag;
        x.outs = e;
        x.cnt  = expStall;
        sbQ.push_back(x);
    endtask

    // Advance one cycle, tracking the stall count the spec predicts.
    task automatic tick(input logic [4:0] e);
        if (rst) expStall = '0;
        else if (!e[4]) expStall = expStall + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic ldUse(input logic [4:0] rd);
        ex_rd = rd; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    endtask

    task automatic test_reset();
        exp_t x;
        logic [4:0] e;
        for (int i = 0; i < 4; i++) begin
            idle();
            e = E_RUN;
            rst = (i < 3);
            case (i)
                0: begin mem_access = 1'b1; end
                1: begin id_rs = 5'd8; id_use_rs = 1'b1; ldUse(5'd8); end
                2: begin id_branch = 1'b1; id_taken = 1'b1; end
                default: ;
            endcase
            pushExp($sformatf("reset[%0d]", i), e);
            #1;
            x = sbQ.pop_front();
            nTests++;
            if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze} !== x.outs ||
                stall_count !== x.cnt) begin
                nFail++;
                $display("FAIL %s: got outs=%b count=%0d, want outs=%b count=%0d", x.tag,
                         {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze},
                         stall_count, x.outs, x.cnt);
            end
            tick(x.outs);
        end
    endtask

    task automatic test_load_use();
        exp_t x;
        logic [4:0] e;
        for (int i = 0; i < 5; i++) begin
            idle();
            id_rs = 5'd8; id_use_rs = 1'b1; id_rt = 5'd9; id_use_rt = 1'b1;
            case (i)
                0: begin ldUse(5'd8); e = E_STALL; end
                1: begin mem_mem_read = 1'b1; mem_rd = 5'd8; mem_access = 1'b1;
                         mem_ready = 1'b1; e = E_STALL; end
                2: e = E_RUN;
                3: begin id_use_rt = 1'b0; ldUse(5'd9); e = E_RUN; end
                default: begin id_rs = 5'd0; id_rt = 5'd0; ldUse(5'd0); e = E_RUN; end
            endcase
            pushExp($sformatf("load_use[%0d]", i), e);
            #1;
            x = sbQ.pop_front();
            nTests++;
            if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze} !== x.outs ||
                stall_count !== x.cnt) begin
                nFail++;
                $display("FAIL %s: got outs=%b count=%0d, want outs=%b count=%0d", x.tag,
                         {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze},
                         stall_count, x.outs, x.cnt);
            end
            tick(x.outs);
        end
    endtask

    task automatic test_branch_operand();
        exp_t x;
        logic [4:0] e;
        for (int i = 0; i < 8; i++) begin
            idle();
            id_branch = 1'b1; id_rs = 5'd9; id_use_rs = 1'b1;
            case (i)
                0: begin ex_reg_write = 1'b1; ex_rd = 5'd9; e = E_STALL; end
                1: begin mem_mem_read = 1'b1; mem_rd = 5'd9; mem_access = 1'b1;
                         mem_ready = 1'b1; e = E_STALL; end
                2: begin mem_rd = 5'd9; e = E_RUN; end
                3: begin id_rs = 5'd0; ex_reg_write = 1'b1; ex_rd = 5'd0; e = E_RUN; end
                4: begin id_use_rs = 1'b0; id_rt = 5'd9; id_use_rt = 1'b1; ex_rd = 5'd9; e = E_RUN; end
                5: begin id_branch = 1'b0; ex_reg_write = 1'b1; ex_rd = 5'd9; e = E_RUN; end
                6: begin id_use_rs = 1'b0; id_rt = 5'd12; id_use_rt = 1'b1; mem_mem_read = 1'b1;
                         mem_rd = 5'd12; mem_access = 1'b1; mem_ready = 1'b1; e = E_STALL; end
                default: begin idle(); e = E_RUN; end
            endcase
            pushExp($sformatf("branch_op[%0d]", i), e);
            #1;
            x = sbQ.pop_front();
            nTests++;
            if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze} !== x.outs ||
                stall_count !== x.cnt) begin
                nFail++;
                $display("FAIL %s: got outs=%b count=%0d, want outs=%b count=%0d", x.tag,
                         {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze},
                         stall_count, x.outs, x.cnt);
            end
            tick(x.outs);
        end
    endtask

    task automatic test_mdu();
        exp_t x;
        logic [4:0] e;
        for (int i = 0; i < 16; i++) begin
            idle();
            e = E_RUN;
            case (i)
                0, 5, 10: ex_mdu_start = 1'b1;
                1, 2, 3:  begin id_hilo_rd = 1'b1; e = E_STALL; end
                4:        id_hilo_rd = 1'b1;
                6, 7, 8:  begin id_mdu = 1'b1; e = E_STALL; end
                9:        id_mdu = 1'b1;
                11:       begin id_hilo_rd = 1'b1; mem_access = 1'b1; e = E_FRZ; end
                12, 13, 14: begin id_hilo_rd = 1'b1; e = E_STALL; end
                default:  id_hilo_rd = 1'b1;
            endcase
            pushExp($sformatf("mdu[%0d]", i), e);
            #1;
            x = sbQ.pop_front();
            nTests++;
            if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze} !== x.outs ||
                stall_count !== x.cnt) begin
                nFail++;
                $display("FAIL %s: got outs=%b count=%0d, want outs=%b count=%0d", x.tag,
                         {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze},
                         stall_count, x.outs, x.cnt);
            end
            tick(x.outs);
        end
    endtask

    task automatic test_freeze_in_hold();
        exp_t x;
        logic [4:0] e;
        for (int i = 0; i < 8; i++) begin
            idle();
            id_rs = 5'd8; id_use_rs = 1'b1;
            if (i == 0) begin
                ldUse(5'd8);
                e = E_STALL;
            end else if (i <= 6) begin
                mem_mem_read = 1'b1; mem_rd = 5'd8; mem_access = 1'b1;
                mem_ready = (i == 6);
                e = (i == 6) ? E_STALL : E_FRZ;
            end else begin
                e = E_RUN;
            end
            pushExp($sformatf("freeze_hold[%0d]", i), e);
            #1;
            x = sbQ.pop_front();
            nTests++;
            if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze} !== x.outs ||
                stall_count !== x.cnt) begin
                nFail++;
                $display("FAIL %s: got outs=%b count=%0d, want outs=%b count=%0d", x.tag,
                         {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze},
                         stall_count, x.outs, x.cnt);
            end
            tick(x.outs);
        end
    endtask

    task automatic test_taken();
        exp_t x;
        logic [4:0] e;
        for (int i = 0; i < 8; i++) begin
            idle();
            id_branch = 1'b1; id_taken = 1'b1; id_rs = 5'd3; id_use_rs = 1'b1;
            case (i)
                0: e = E_FLUSH;
                1: begin idle(); e = E_RUN; end
                2: begin id_rs = 5'd8; ldUse(5'd8); e = E_STALL; end
                3: begin id_rs = 5'd8; mem_mem_read = 1'b1; mem_rd = 5'd8; mem_access = 1'b1;
                         mem_ready = 1'b1; e = E_STALL; end
                4: e = E_FLUSH;
                5: begin mem_access = 1'b1; e = E_FRZ; end
                6: begin mem_access = 1'b1; mem_ready = 1'b1; e = E_FLUSH; end
                default: begin idle(); e = E_RUN; end
            endcase
            pushExp($sformatf("taken[%0d]", i), e);
            #1;
            x = sbQ.pop_front();
            nTests++;
            if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze} !== x.outs ||
                stall_count !== x.cnt) begin
                nFail++;
                $display("FAIL %s: got outs=%b count=%0d, want outs=%b count=%0d", x.tag,
                         {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze},
                         stall_count, x.outs, x.cnt);
            end
            tick(x.outs);
        end
    endtask

    task automatic test_back_to_back();
        exp_t x;
        logic [4:0] e;
        for (int i = 0; i < 5; i++) begin
            idle();
            id_use_rs = 1'b1;
            id_rs = (i < 2) ? 5'd8 : 5'd9;
            e = E_STALL;
            case (i)
                0: ldUse(5'd8);
                2: ldUse(5'd9);
                4: e = E_RUN;
                default: ;
            endcase
            pushExp($sformatf("back_to_back[%0d]", i), e);
            #1;
            x = sbQ.pop_front();
            nTests++;
            if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze} !== x.outs ||
                stall_count !== x.cnt) begin
                nFail++;
                $display("FAIL %s: got outs=%b count=%0d, want outs=%b count=%0d", x.tag,
                         {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze},
                         stall_count, x.outs, x.cnt);
            end
            tick(x.outs);
        end
    endtask

    task automatic test_reset_mid_hold();
        exp_t x;
        logic [4:0] e;
        for (int i = 0; i < 3; i++) begin
            idle();
            id_rs = 5'd8; id_use_rs = 1'b1;
            rst = (i == 1);
            if (i < 2) ldUse(5'd8);
            e = (i == 0) ? E_STALL : E_RUN;
            pushExp($sformatf("reset_hold[%0d]", i), e);
            #1;
            x = sbQ.pop_front();
            nTests++;
            if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze} !== x.outs ||
                stall_count !== x.cnt) begin
                nFail++;
                $display("FAIL %s: got outs=%b count=%0d, want outs=%b count=%0d", x.tag,
                         {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze},
                         stall_count, x.outs, x.cnt);
            end
            tick(x.outs);
        end
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        exp_t x;
        logic [4:0] e;
        logic [2:0] satExp;
        for (int i = 0; i < 11; i++) begin
            idle();
            mem_access = 1'b1;
            mem_ready = (i == 10);
            e = (i == 10) ? E_RUN : E_FRZ;
            satExp = (expStall >= 32'd7) ? 3'd7 : 3'(expStall);
            pushExp($sformatf("saturate[%0d]", i), e);
            #1;
            x = sbQ.pop_front();
            nTests++;
            if ({satPc, satIfId, satFlush, satBubble, satFreeze} !== x.outs ||
                satCount !== satExp || stall_count !== x.cnt) begin
                nFail++;
                $display("FAIL %s: got outs=%b count=%0d narrow=%0d, want outs=%b count=%0d narrow=%0d",
                         x.tag, {satPc, satIfId, satFlush, satBubble, satFreeze}, stall_count,
                         satCount, x.outs, x.cnt, satExp);
            end
            tick(x.outs);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch_operand();
        test_mdu();
        test_freeze_in_hold();
        test_taken();
        test_back_to_back();
        test_reset_mid_hold();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
